// File: rtl/bless_ni.sv
// BLESS mesh node network interface: packetizes core words into tagged flits
// for injection and timestamps ejected flits with their network latency.
module bless_ni #(
    parameter int PKT_ID_W  = 8,
    parameter int FLIT_ID_W = 3,
    parameter int TIME_W    = 8,
    parameter int COORD_W   = 3,
    parameter int DATA_W    = 32,
    parameter int INJ_DEPTH = 4,
    parameter int FLIT_W    = PKT_ID_W + FLIT_ID_W + TIME_W + 2*COORD_W + DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [COORD_W-1:0]  tx_xdst,
    input  logic [COORD_W-1:0]  tx_ydst,
    input  logic                tx_last,
    input  logic                inj_allow,
    output logic [FLIT_W-1:0]   dinLocal,
    input  logic [FLIT_W-1:0]   doutLocal,
    output logic                rx_valid,
    output logic [FLIT_W-1:0]   rx_flit,
    output logic [TIME_W-1:0]   rx_latency,
    output logic [TIME_W-1:0]   time_now,
    output logic [15:0]         inj_cnt,
    output logic [15:0]         ej_cnt
);
    localparam int AW       = $clog2(INJ_DEPTH);
    localparam int TIME_LSB = DATA_W + 2*COORD_W;

    logic [FLIT_W-1:0]    fifo [INJ_DEPTH];
    logic [AW:0]          wrPtr, rdPtr;
    logic                 empty, full, push, pop;
    logic [PKT_ID_W-1:0]  curPktId;
    logic [FLIT_ID_W-1:0] flitCnt;
    logic                 inPacket;
    logic [TIME_W-1:0]    pktTime, flitTime;
    logic [COORD_W-1:0]   pktX, pktY, flitX, flitY;
    logic                 endPkt;
    logic [FLIT_W-1:0]    newFlit;

    // Extra pointer bit distinguishes full from empty.
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign tx_ready = !full;
    assign push     = tx_valid && !full;
    assign pop      = !empty && inj_allow;

    // Header fields are latched on the first word and reused for the rest of the packet.
    assign flitTime = inPacket ? pktTime : time_now;
    assign flitX    = inPacket ? pktX    : tx_xdst;
    assign flitY    = inPacket ? pktY    : tx_ydst;
    assign newFlit  = {curPktId, flitCnt, flitTime, flitX, flitY, tx_data};
    assign endPkt   = tx_last || (flitCnt == {FLIT_ID_W{1'b1}});

    always_ff @(posedge clk) begin
        if (push) fifo[wrPtr[AW-1:0]] <= newFlit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            curPktId   <= PKT_ID_W'(1);
            flitCnt    <= '0;
            inPacket   <= 1'b0;
            pktTime    <= '0;
            pktX       <= '0;
            pktY       <= '0;
            dinLocal   <= '0;
            rx_valid   <= 1'b0;
            rx_flit    <= '0;
            rx_latency <= '0;
            time_now   <= '0;
            inj_cnt    <= '0;
            ej_cnt     <= '0;
        end else begin
            time_now <= time_now + 1'b1;

            if (push) begin
                wrPtr   <= wrPtr + 1'b1;
                pktTime <= flitTime;
                pktX    <= flitX;
                pktY    <= flitY;
                if (endPkt) begin
                    flitCnt  <= '0;
                    inPacket <= 1'b0;
                    // ID 0 means "no flit", so the counter skips it on wrap.
                    curPktId <= (curPktId == {PKT_ID_W{1'b1}}) ? PKT_ID_W'(1) : curPktId + 1'b1;
                end else begin
                    flitCnt  <= flitCnt + 1'b1;
                    inPacket <= 1'b1;
                end
            end

            if (pop) begin
                dinLocal <= fifo[rdPtr[AW-1:0]];
                rdPtr    <= rdPtr + 1'b1;
                inj_cnt  <= inj_cnt + 16'd1;
            end else begin
                dinLocal <= '0;
            end

            // Router is bufferless: every non-empty flit is taken immediately.
            if (doutLocal != '0) begin
                rx_valid   <= 1'b1;
                rx_flit    <= doutLocal;
                rx_latency <= time_now - doutLocal[TIME_LSB +: TIME_W];
                ej_cnt     <= ej_cnt + 16'd1;
            end else begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bless_ni.sv
// Randomized and directed bench for bless_ni against a queue-based flit model.
module tb_bless_ni;
    localparam int FW = 57;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_valid, tx_ready, tx_last, inj_allow;
    logic [31:0]   tx_data;
    logic [2:0]    tx_xdst, tx_ydst;
    logic [FW-1:0] dinLocal, doutLocal, rx_flit;
    logic          rx_valid;
    logic [7:0]    rx_latency, time_now;
    logic [15:0]   inj_cnt, ej_cnt;

    bless_ni dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_xdst(tx_xdst), .tx_ydst(tx_ydst), .tx_last(tx_last),
        .inj_allow(inj_allow), .dinLocal(dinLocal), .doutLocal(doutLocal),
        .rx_valid(rx_valid), .rx_flit(rx_flit), .rx_latency(rx_latency),
        .time_now(time_now), .inj_cnt(inj_cnt), .ej_cnt(ej_cnt)
    );

    always #5 clk = ~clk;

    int nChk = 0, nFail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of pending flits plus packet bookkeeping.
    logic [FW-1:0] mq[$];
    bit [7:0]  mTime, mPid, mPt;
    bit [2:0]  mIdx, mX, mY;
    bit        mIn;
    bit [15:0] mInj, mEj;
    logic [FW-1:0] exDin, exRxF;
    bit        exRxV;
    bit [7:0]  exRxL;
    int        nAcc;

    task automatic mReset();
        mq.delete();
        mTime = 0; mPid = 1; mIdx = 0; mIn = 0; mInj = 0; mEj = 0;
        exDin = '0; exRxF = '0; exRxV = 0; exRxL = 0;
    endtask

    function automatic logic [FW-1:0] mkFlit(input bit [7:0] pid, input bit [7:0] t, input bit [31:0] d);
        return {pid, 3'd0, t, 3'd1, 3'd2, d};
    endfunction

    task automatic cyc(input bit v, input bit [31:0] d, input bit [2:0] x, input bit [2:0] y,
                       input bit last, input bit allow, input logic [FW-1:0] dout);
        bit acc;
        tx_valid = v; tx_data = d; tx_xdst = x; tx_ydst = y; tx_last = last;
        inj_allow = allow; doutLocal = dout;
        acc = v && (mq.size() < 4);
        chk("tx_ready", tx_ready, mq.size() < 4);
        if (allow && mq.size() > 0) begin
            exDin = mq.pop_front();
            mInj++;
        end else exDin = '0;
        if (acc) begin
            if (!mIn) begin mPt = mTime; mX = x; mY = y; end
            mq.push_back({mPid, mIdx, mPt, mX, mY, d});
            nAcc++;
            if (last || mIdx == 7) begin
                mPid = mPid % 255 + 1;
                mIdx = 0; mIn = 0;
            end else begin
                mIdx++; mIn = 1;
            end
        end
        if (dout != '0) begin
            exRxV = 1; exRxF = dout; exRxL = mTime - dout[45:38]; mEj++;
        end else exRxV = 0;
        mTime++;
        @(posedge clk); #1;
        chk("dinLocal", dinLocal, exDin);
        chk("rx_valid", rx_valid, exRxV);
        chk("rx_flit", rx_flit, exRxF);
        chk("rx_latency", rx_latency, exRxL);
        chk("time_now", time_now, mTime);
        chk("inj_cnt", inj_cnt, mInj);
        chk("ej_cnt", ej_cnt, mEj);
    endtask

    task automatic idle(input bit allow);
        cyc(0, 0, 0, 0, 0, allow, '0);
    endtask

    task automatic doReset(input int n);
        tx_valid = 0; tx_last = 0; doutLocal = '0; inj_allow = 0;
        reset = 1;
        repeat (n) @(posedge clk);
        #1;
        reset = 0;
        mReset();
        chk("rst_din", dinLocal, '0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_time", time_now, 0);
        chk("rst_injcnt", inj_cnt, 0);
        chk("rst_ejcnt", ej_cnt, 0);
    endtask

    initial begin
        logic [15:0] i0, e0;
        logic [FW-1:0] r;
        tx_data = 0; tx_xdst = 0; tx_ydst = 0;
        doReset(2);

        // Single 3-flit packet accepted starting at time 5
        while (mTime != 5) idle(1);
        cyc(1, 32'hA, 2, 1, 0, 1, '0);
        cyc(1, 32'hB, 2, 1, 0, 1, '0);
        chk("single_f0", dinLocal, {8'd1, 3'd0, 8'd5, 3'd2, 3'd1, 32'hA});
        cyc(1, 32'hC, 2, 1, 1, 1, '0);
        idle(1);
        chk("single_f2", dinLocal, {8'd1, 3'd2, 8'd5, 3'd2, 3'd1, 32'hC});
        idle(1);
        chk("single_inj", inj_cnt, 3);

        // Backpressure: only 4 of 6 words fit
        nAcc = 0;
        repeat (6) cyc(1, $urandom, 3, 3, 0, 0, '0);
        chk("bp_acc", nAcc, 4);
        chk("bp_ready", tx_ready, 0);
        repeat (4) idle(1);
        chk("bp_ready_back", tx_ready, 1);

        // Reset mid-traffic with 3 flits buffered
        repeat (3) cyc(1, $urandom, 1, 1, 0, 0, '0);
        doReset(2);

        // Forced split at 8 flits
        for (int i = 0; i < 9; i++) cyc(1, i, 4, 5, i == 8, 1, '0);
        idle(1);
        chk("split_pid", dinLocal[56:49], 2);
        chk("split_fid", dinLocal[48:46], 0);
        idle(1);

        // PktId wrap skips 0
        doReset(1);
        for (int i = 0; i < 256; i++) cyc(1, i, 0, 0, 1, 1, '0);
        idle(1);
        chk("wrap_pid", dinLocal[56:49], 1);

        // Ejection latency
        while (mTime != 25) idle(0);
        cyc(0, 0, 0, 0, 0, 0, mkFlit(8'd7, 8'd10, 32'h1));
        chk("lat15_v", rx_valid, 1);
        chk("lat15", rx_latency, 15);
        while (mTime != 4) idle(0);
        cyc(0, 0, 0, 0, 0, 0, mkFlit(8'd9, 8'd250, 32'h2));
        chk("lat10", rx_latency, 10);
        idle(0);
        e0 = ej_cnt;
        cyc(0, 0, 0, 0, 0, 0, mkFlit(8'd3, 8'd1, 32'h3));
        chk("b2b_v0", rx_valid, 1);
        cyc(0, 0, 0, 0, 0, 0, mkFlit(8'd4, 8'd2, 32'h4));
        chk("b2b_v1", rx_valid, 1);
        chk("b2b_cnt", ej_cnt - e0, 2);
        idle(0);

        // Concurrent injection and ejection
        i0 = inj_cnt; e0 = ej_cnt;
        for (int i = 0; i < 4; i++)
            cyc(1, 32'h100 + i, 6, 7, i == 3, 1, mkFlit(8'd20 + 8'(i), 8'(i), 32'h55));
        repeat (2) idle(1);
        chk("conc_inj", inj_cnt - i0, 4);
        chk("conc_ej", ej_cnt - e0, 4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 1) ? FW'({$urandom(), $urandom()}) : '0;
            cyc($urandom_range(0, 1), $urandom, 3'($urandom), 3'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 1), r);
        end
        repeat (6) idle(1);

        $display("%0d/%0d checks passed", nChk - nFail, nChk);
        $finish;
    end
endmodule

// File: doc/bless_ni.md
Name: bless_ni

Overview:
- Network interface for one BLESS mesh node: the local-port end of the router, facing the core.
- Injection side: packetizes core data words into flits, tags them with PktId, FlitId, injection Time and destination, buffers them, and drives the router's local input when the router grants an injection slot.
- Ejection side: accepts flits from the router's local output with no stall, since the router is bufferless, and presents them to the core with measured network latency.

Parameters:
- PKT_ID_W, 8, packet ID field width; ID 0 is reserved to mean "no flit".
- FLIT_ID_W, 3, flit index width; maximum packet length is 2^FLIT_ID_W = 8 flits.
- TIME_W, 8, injection timestamp / free-running time counter width.
- COORD_W, 3, X and Y destination field width each.
- DATA_W, 32, payload width.
- INJ_DEPTH, 4, injection FIFO depth in flits (power of 2).
- FLIT_W, PKT_ID_W+FLIT_ID_W+TIME_W+2*COORD_W+DATA_W (default 57), derived; flit layout MSB to LSB is {PktId, FlitId, Time, Xdst, Ydst, payload}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  core offers a data word
- tx_ready  out  1  NI accepts a word this cycle (tx_valid & tx_ready = accept)
- tx_data  in  DATA_W  payload word
- tx_xdst  in  COORD_W  destination X; sampled on the first word of a packet only
- tx_ydst  in  COORD_W  destination Y; sampled on the first word of a packet only
- tx_last  in  1  word is the last of its packet
- inj_allow  in  1  router has a free output slot this cycle (fewer than 4 valid network inputs)
- dinLocal  out  FLIT_W  flit to router local input; all-zero means idle
- doutLocal  in  FLIT_W  flit from router local output; all-zero means empty
- rx_valid  out  1  ejected flit valid
- rx_flit  out  FLIT_W  ejected flit
- rx_latency  out  TIME_W  time_now minus flit Time, mod 2^TIME_W
- time_now  out  TIME_W  free-running time counter
- inj_cnt  out  16  flits injected (wraps)
- ej_cnt  out  16  flits ejected (wraps)

Behaviour:
- Reset (sampled at posedge while reset=1) sets the following; any partial packet is discarded, FIFO contents are lost, and no flit emerges in the reset cycle or the cycle after:
  - dinLocal=0, rx_valid=0, rx_flit=0, rx_latency=0
  - time_now=0, inj_cnt=0, ej_cnt=0
  - FIFO empty, tx_ready=1
  - current PktId=1, FlitId counter=0, in_packet=0
- time_now increments by 1 every non-reset cycle and wraps modulo 2^TIME_W.
- tx_ready = FIFO not full, computed from registered state only. There is no bypass: a pop in the same cycle does not make a full FIFO accept a push.
- Word accept:
  - Builds flit {cur_pkt_id, flit_cnt, pkt_time, xdst, ydst, tx_data} and pushes it to the FIFO.
  - On the first word of a packet (in_packet=0), pkt_time, xdst and ydst are taken from time_now, tx_xdst and tx_ydst of that cycle, and the same values are used for every flit of the packet.
- End of packet occurs on accept with tx_last=1, or on accept when flit_cnt = 2^FLIT_ID_W-1 (forced split).
  - At end of packet: flit_cnt returns to 0, in_packet clears, and cur_pkt_id increments, wrapping 2^PKT_ID_W-1 to 1 and never reaching 0.
  - A forced split continues the following words as a new packet with a new ID, Time and destination sample.
- Injection (registered):
  - Each cycle, if the FIFO is non-empty and inj_allow=1: dinLocal takes the FIFO head, the head is popped, and inj_cnt increments.
  - Otherwise dinLocal=0.
  - A flit never holds on dinLocal for more than one cycle.
  - Minimum latency: word accepted at edge N is visible on dinLocal after edge N+1.
  - FIFO order is strict; flits of a packet leave in FlitId order.
- Ejection (registered, 1 cycle):
  - If doutLocal != 0: rx_valid=1, rx_flit=doutLocal, rx_latency=time_now - doutLocal.Time (mod 2^TIME_W, using time_now before its increment), and ej_cnt increments.
  - Otherwise rx_valid=0 and rx_flit/rx_latency hold their last value.
  - Back-to-back flits are accepted every cycle; there is no backpressure.
- Injection and ejection are fully independent. A simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.

Test Plan:
- Reset check: hold reset 2 cycles mid-traffic (FIFO holding 3 flits), then release. Required: dinLocal=0, tx_ready=1, rx_valid=0, time_now=0 the cycle after release, and the first subsequent packet has PktId=1.
- Single packet: inj_allow=1; accept 3 words at time_now=5, dst (2,1), data A,B,C, tx_last on C. Required: dinLocal shows PktId=1, FlitId 0,1,2, Time=5, X=2, Y=1 on 3 consecutive cycles starting one cycle after A is accepted; inj_cnt=3.
- Backpressure: inj_allow=0; offer 6 words. Required: exactly 4 accepted and tx_ready=0 afterwards, dinLocal stays 0. Then raise inj_allow: the 4 flits drain in order, one per cycle, and tx_ready returns to 1.
- Split and wrap:
  - 9 words with tx_last only on the 9th: flits 1–8 are PktId=1, FlitId 0–7; flit 9 is PktId=2, FlitId 0.
  - Separately, 255 one-word packets: the 256th packet carries PktId=1, not 0.
- Ejection latency:
  - doutLocal with Time=10 at time_now=25: next cycle rx_valid=1, rx_latency=15.
  - Time=250 at time_now=4: rx_latency=10.
  - Two back-to-back flits give rx_valid high for 2 cycles and ej_cnt=+2.
- Concurrency: inject a 4-flit packet and eject 4 flits in the same cycles. Required: no lost flits, inj_cnt=4, ej_cnt=4, and dinLocal order is unaffected.
